serial_lut_dbuf: RTL and testbench
==================================

# serial_lut_dbuf

Double-buffered, parametrised successor to the serial-load LUT tile. A table is shifted serially into a shadow register, with a frame bit counter running alongside it. The shadow is committed atomically to the active table only when a frame of exactly the right length ends. The active table can rotate by a parametrised amount while a new frame is loading, and the selected entry is driven from a registered output, so `out` never shows partially loaded data.

## Interface
Parameters:
- `IN_WIDTH`, 2, select width; table holds 2**IN_WIDTH entries
- `OUT_WIDTH`, 8, entry width
- `ROT_LEN`, 8, rotate amount in bits (1 ≤ ROT_LEN < TABLE_BITS)
- derived `TABLE_BITS` = 2**IN_WIDTH * OUT_WIDTH (32 by default)

Ports (one clock; reset is asynchronous and active-low):
- `clk`  in  1  rising-edge clock
- `rst_n`  in  1  asynchronous active-low reset
- `d`  in  1  serial table data, MSB of table first
- `cs_n`  in  1  frame enable; low = shift `d` into shadow
- `rot_n`  in  1  low = rotate active table this cycle
- `sel`  in  IN_WIDTH  entry select
- `out`  out  OUT_WIDTH  registered active[sel]
- `valid`  out  1  at least one good commit since reset
- `err`  out  1  sticky: last frame had a wrong length

## Operation
- Registers: `shadow[TABLE_BITS]`, `active[TABLE_BITS]`, `cnt` (saturating at TABLE_BITS+1), `cs_q` (previous cs_n), `out`, `valid`, `err`.
- Implicit FSM held in `cs_q`:
  - IDLE (cs_q=1)
  - LOAD (cs_q=0)
- Frame start (cs_n=0, cs_q=1):
  - shadow <= {shadow[TABLE_BITS-2:0], d}
  - cnt <= 1
  - err <= 0
- In LOAD (cs_n=0, cs_q=0):
  - shift as at frame start
  - cnt <= min(cnt+1, TABLE_BITS+1); the counter never wraps
- Frame end (cs_n=1, cs_q=0):
  - if cnt == TABLE_BITS: active <= shadow, valid <= 1
  - otherwise: err <= 1; active and valid are unchanged
  - shadow keeps its contents either way
- Rotate (rot_n=0, no commit this edge):
  - active <= {active[ROT_LEN-1:0], active[TABLE_BITS-1:ROT_LEN]}
  - allowed in both IDLE and LOAD
- Commit and rotate on the same edge: commit wins, the rotation is dropped.
- Entry i = active[(i+1)*OUT_WIDTH-1 -: OUT_WIDTH].
- out <= entry[sel] every edge, using the pre-edge value of `active`.
- Reset value of every output: out=0, valid=0, err=0. Internal reset: shadow=0, active=0, cnt=0, cs_q=1.

## Timing
- `sel` to `out`: 1 cycle.
- Commit at edge N: `out` reflects the new table from edge N+1.
- Rotate at edge N: `out` reflects the rotated table from edge N+1.
- `valid` and `err` update on the frame-end edge.
- Reset asserted mid-frame: all state clears immediately. The next low cs_n sample after reset release counts as a frame start.
- A frame of zero length cannot occur, because a frame start always counts 1.

## Structure
- Shared package `serial_lut_pkg`:
  - function `table_bits(in_w, out_w)`
  - `localparam` defaults for IN_WIDTH, OUT_WIDTH and ROT_LEN, shared with the top-level wrapper
- Sub-module `lut_mux`: purely combinational entry select over `active`, parametrised by IN_WIDTH and OUT_WIDTH.
- The shift, count and commit logic lives in the top module.

## Test plan
All tests use default parameters unless stated.
- Reset, then sel=0..3 → out=0x00, valid=0, err=0.
- Good load: shift 32 bits of 0x11223344 MSB first, then raise cs_n.
  - valid=1, err=0
  - sel=3 → 0x11, sel=0 → 0x44, each one cycle after `sel` is applied
- Rotate after the good load: rot_n low for 1 cycle → active=0x44112233; sel=0 → 0x33, sel=3 → 0x44.
- Short (31-bit) and long (33-bit, and 40-bit to exercise saturation) frames after the good load → err=1 and out unchanged.
  - A following good frame of 0xA5A5A5A5 clears err at frame start; sel=0 → 0xA5.
- Rotate during LOAD, then a simultaneous commit+rotate edge:
  - rotation during the load applies to the old table
  - on the commit edge, active = new shadow with no rotation
- Reset mid-frame at bit 16 → all outputs 0, valid=0. A full 32-bit frame after release commits normally.

Source files
------------

// File: rtl/serial_lut_pkg.sv
// rtl/serial_lut_pkg.sv - shared parameters, types and helpers for the serial LUT tile
package serial_lut_pkg;

    localparam int DEF_IN_WIDTH  = 2;
    localparam int DEF_OUT_WIDTH = 8;
    localparam int DEF_ROT_LEN   = 8;

    // Frame state is just the previous cs_n sample: high means idle.
    typedef enum logic {
        ST_LOAD = 1'b0,
        ST_IDLE = 1'b1
    } frame_state_t;

    function automatic int table_bits(input int in_w, input int out_w);
        return (1 << in_w) * out_w;
    endfunction

endpackage

// File: rtl/lut_mux.sv
// rtl/lut_mux.sv - combinational entry select over a flat packed table
module lut_mux
    import serial_lut_pkg::*;
#(
    parameter int IN_WIDTH  = DEF_IN_WIDTH,
    parameter int OUT_WIDTH = DEF_OUT_WIDTH
) (
    input  logic [table_bits(IN_WIDTH, OUT_WIDTH)-1:0] lut_i,
    input  logic [IN_WIDTH-1:0]                        sel_i,
    output logic [OUT_WIDTH-1:0]                       entry_o
);

    localparam int ENTRIES = 2 ** IN_WIDTH;

    logic [OUT_WIDTH-1:0] entries [ENTRIES];

    // Entry 0 sits in the least significant slice of the table.
    for (genvar i = 0; i < ENTRIES; i++) begin : g_entry
        assign entries[i] = lut_i[(i+1)*OUT_WIDTH-1 -: OUT_WIDTH];
    end

    assign entry_o = entries[sel_i];

endmodule

// File: rtl/serial_lut_dbuf.sv
// rtl/serial_lut_dbuf.sv - double-buffered serial-load LUT with rotate and registered output
module serial_lut_dbuf
    import serial_lut_pkg::*;
#(
    parameter int IN_WIDTH  = DEF_IN_WIDTH,
    parameter int OUT_WIDTH = DEF_OUT_WIDTH,
    parameter int ROT_LEN   = DEF_ROT_LEN
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 d,
    input  logic                 cs_n,
    input  logic                 rot_n,
    input  logic [IN_WIDTH-1:0]  sel,
    output logic [OUT_WIDTH-1:0] out,
    output logic                 valid,
    output logic                 err
);

    localparam int TABLE_BITS = table_bits(IN_WIDTH, OUT_WIDTH);
    localparam int CNT_W      = $clog2(TABLE_BITS + 2);

    localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(TABLE_BITS);
    localparam logic [CNT_W-1:0] CNT_SAT  = CNT_W'(TABLE_BITS + 1);

    logic [TABLE_BITS-1:0] shadow_q, shadow_d;
    logic [TABLE_BITS-1:0] active_q, active_d;
    logic [CNT_W-1:0]      cnt_q, cnt_d;
    frame_state_t          cs_q, cs_d;
    logic [OUT_WIDTH-1:0]  out_q, out_d;
    logic                  valid_q, valid_d;
    logic                  err_q, err_d;

    logic [OUT_WIDTH-1:0]  entry;
    logic                  frame_end;
    logic                  commit;

    lut_mux #(
        .IN_WIDTH  (IN_WIDTH),
        .OUT_WIDTH (OUT_WIDTH)
    ) u_lut_mux (
        .lut_i   (active_q),
        .sel_i   (sel),
        .entry_o (entry)
    );

    assign frame_end = cs_n && (cs_q == ST_LOAD);
    assign commit    = frame_end && (cnt_q == CNT_FULL);

    always_comb begin
        shadow_d = shadow_q;
        active_d = active_q;
        cnt_d    = cnt_q;
        valid_d  = valid_q;
        err_d    = err_q;
        cs_d     = cs_n ? ST_IDLE : ST_LOAD;
        out_d    = entry;

        if (!cs_n) begin
            shadow_d = {shadow_q[TABLE_BITS-2:0], d};
            if (cs_q == ST_IDLE) begin
                cnt_d = CNT_W'(1);
                err_d = 1'b0;
            end else if (cnt_q != CNT_SAT) begin
                cnt_d = cnt_q + CNT_W'(1);
            end
        end else if (frame_end && !commit) begin
            err_d = 1'b1;
        end

        // A commit replaces the whole table, so a same-edge rotate is dropped.
        if (commit) begin
            active_d = shadow_q;
            valid_d  = 1'b1;
        end else if (!rot_n) begin
            active_d = {active_q[ROT_LEN-1:0], active_q[TABLE_BITS-1:ROT_LEN]};
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            shadow_q <= '0;
            active_q <= '0;
            cnt_q    <= '0;
            cs_q     <= ST_IDLE;
            out_q    <= '0;
            valid_q  <= 1'b0;
            err_q    <= 1'b0;
        end else begin
            shadow_q <= shadow_d;
            active_q <= active_d;
            cnt_q    <= cnt_d;
            cs_q     <= cs_d;
            out_q    <= out_d;
            valid_q  <= valid_d;
            err_q    <= err_d;
        end
    end

    assign out   = out_q;
    assign valid = valid_q;
    assign err   = err_q;

endmodule

// File: tb/tb_serial_lut_dbuf.sv
// tb/tb_serial_lut_dbuf.sv - self-checking bench for serial_lut_dbuf
module tb_serial_lut_dbuf;

    localparam int TB_BITS = 32;
    localparam int TB_ROT  = 8;

    logic       clk;
    logic       rst_n;
    logic       d;
    logic       cs_n;
    logic       rot_n;
    logic [1:0] sel;
    logic [7:0] out;
    logic       valid;
    logic       err;

    int tests_run = 0;
    int tests_failed = 0;

    serial_lut_dbuf dut (
        .clk   (clk),
        .rst_n (rst_n),
        .d     (d),
        .cs_n  (cs_n),
        .rot_n (rot_n),
        .sel   (sel),
        .out   (out),
        .valid (valid),
        .err   (err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #800000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Reference model: table as a 32-bit word, frame length as a plain count.
    bit [31:0] m_shadow, m_active;
    bit [7:0]  m_out;
    bit        m_valid, m_err, m_in_frame;
    int        m_len;

    task automatic model_reset();
        m_shadow = '0; m_active = '0; m_out = '0;
        m_valid = 0; m_err = 0; m_in_frame = 0; m_len = 0;
    endtask

    task automatic model_step(input bit d_v, input bit cs_v, input bit rot_v, input bit [1:0] sel_v);
        bit do_commit;
        do_commit = 0;
        m_out = 8'((m_active >> (int'(sel_v) * 8)) & 32'hFF);
        if (!cs_v) begin
            if (!m_in_frame) begin
                m_len = 1;
                m_err = 0;
            end else begin
                m_len++;
            end
            m_in_frame = 1;
            m_shadow = (m_shadow << 1) | 32'(d_v);
        end else if (m_in_frame) begin
            m_in_frame = 0;
            if (m_len == TB_BITS) do_commit = 1;
            else m_err = 1;
        end
        if (do_commit) begin
            m_active = m_shadow;
            m_valid = 1;
        end else if (!rot_v) begin
            m_active = (m_active >> TB_ROT) | (m_active << (TB_BITS - TB_ROT));
        end
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests_run++;
        if (act !== exp) begin
            tests_failed++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // One clock: drive at negedge, step the model on posedge, compare at next negedge.
    task automatic cycle(input bit d_v, input bit cs_v, input bit rot_v, input bit [1:0] sel_v);
        d = d_v; cs_n = cs_v; rot_n = rot_v; sel = sel_v;
        @(posedge clk);
        model_step(d_v, cs_v, rot_v, sel_v);
        @(negedge clk);
        check("model_out", {24'd0, out}, {24'd0, m_out});
        check("model_valid", {31'd0, valid}, {31'd0, m_valid});
        check("model_err", {31'd0, err}, {31'd0, m_err});
    endtask

    task automatic send_frame(input bit [31:0] data, input int len, input bit [1:0] sel_v);
        bit b;
        for (int i = 0; i < len; i++) begin
            b = (len - 1 - i < 32) ? data[len-1-i] : 1'b0;
            cycle(b, 1'b0, 1'b1, sel_v);
        end
        cycle(1'b0, 1'b1, 1'b1, sel_v);
    endtask

    typedef struct {
        bit [31:0] data;
        int        len;
        int        rots;
        bit [1:0]  sel;
        bit [7:0]  exp_out;
        bit        exp_valid;
        bit        exp_err;
    } vec_t;

    vec_t vecs [9];

    initial begin
        vecs[0] = '{32'h11223344, 32, 0, 2'd3, 8'h11, 1'b1, 1'b0};
        vecs[1] = '{32'h0,         0, 0, 2'd0, 8'h44, 1'b1, 1'b0};
        vecs[2] = '{32'h0,         0, 1, 2'd0, 8'h33, 1'b1, 1'b0};
        vecs[3] = '{32'h0,         0, 0, 2'd3, 8'h44, 1'b1, 1'b0};
        vecs[4] = '{32'h89ABCDEF, 31, 0, 2'd1, 8'h22, 1'b1, 1'b1};
        vecs[5] = '{32'h13579BDF, 33, 0, 2'd2, 8'h11, 1'b1, 1'b1};
        vecs[6] = '{32'hFFFFFFFF, 40, 0, 2'd3, 8'h44, 1'b1, 1'b1};
        vecs[7] = '{32'hA5A5A5A5, 32, 0, 2'd0, 8'hA5, 1'b1, 1'b0};
        vecs[8] = '{32'h0,         0, 0, 2'd2, 8'hA5, 1'b1, 1'b0};

        rst_n = 1'b0; d = 1'b0; cs_n = 1'b1; rot_n = 1'b1; sel = 2'd0;
        model_reset();
        repeat (3) @(negedge clk);
        rst_n = 1'b1;

        for (int s = 0; s < 4; s++) begin
            cycle(1'b0, 1'b1, 1'b1, 2'(s));
            check("reset_out", {24'd0, out}, 32'h0);
            check("reset_valid", {31'd0, valid}, 32'h0);
            check("reset_err", {31'd0, err}, 32'h0);
        end

        for (int v = 0; v < 9; v++) begin
            if (vecs[v].len > 0) send_frame(vecs[v].data, vecs[v].len, vecs[v].sel);
            for (int r = 0; r < vecs[v].rots; r++) cycle(1'b0, 1'b1, 1'b0, vecs[v].sel);
            cycle(1'b0, 1'b1, 1'b1, vecs[v].sel);
            check($sformatf("vec%0d_out", v), {24'd0, out}, {24'd0, vecs[v].exp_out});
            check($sformatf("vec%0d_valid", v), {31'd0, valid}, {31'd0, vecs[v].exp_valid});
            check($sformatf("vec%0d_err", v), {31'd0, err}, {31'd0, vecs[v].exp_err});
        end

        // err clears on the frame-start edge of the next frame
        send_frame(32'h0, 5, 2'd0);
        check("short_err", {31'd0, err}, 32'h1);
        cycle(1'b1, 1'b0, 1'b1, 2'd0);
        check("start_clears_err", {31'd0, err}, 32'h0);
        cycle(1'b0, 1'b1, 1'b1, 2'd0);
        check("one_bit_frame_err", {31'd0, err}, 32'h1);

        // Rotate during LOAD acts on the old table; commit+rotate edge takes the shadow unrotated
        send_frame(32'h11223344, 32, 2'd0);
        begin
            bit [31:0] nd;
            nd = 32'hCAFEBABE;
            for (int i = 0; i < 32; i++) begin
                cycle(nd[31-i], 1'b0, (i == 5) ? 1'b0 : 1'b1, 2'd0);
                if (i == 6) check("rot_in_load", {24'd0, out}, 32'h33);
            end
        end
        cycle(1'b0, 1'b1, 1'b0, 2'd0);
        cycle(1'b0, 1'b1, 1'b1, 2'd0);
        check("commit_wins_sel0", {24'd0, out}, 32'hBE);
        cycle(1'b0, 1'b1, 1'b1, 2'd3);
        check("commit_wins_sel3", {24'd0, out}, 32'hCA);
        check("commit_wins_err", {31'd0, err}, 32'h0);

        // Reset asserted at bit 16 of a frame
        for (int i = 0; i < 16; i++) cycle(1'($urandom), 1'b0, 1'b1, 2'd3);
        #2 rst_n = 1'b0;
        model_reset();
        #1;
        check("midreset_out", {24'd0, out}, 32'h0);
        check("midreset_valid", {31'd0, valid}, 32'h0);
        check("midreset_err", {31'd0, err}, 32'h0);
        @(negedge clk);
        rst_n = 1'b1;
        send_frame(32'h5A5A0FF0, 32, 2'd0);
        cycle(1'b0, 1'b1, 1'b1, 2'd0);
        check("post_reset_out", {24'd0, out}, 32'hF0);
        check("post_reset_valid", {31'd0, valid}, 32'h1);

        // Random frames of assorted lengths with random rotates and selects
        for (int f = 0; f < 80; f++) begin
            int len;
            case ($urandom_range(0, 3))
                0: len = 32;
                1: len = 31;
                2: len = 33;
                default: len = $urandom_range(1, 40);
            endcase
            for (int i = 0; i < len; i++)
                cycle(1'($urandom), 1'b0, ($urandom_range(0, 7) != 0), 2'($urandom));
            repeat ($urandom_range(1, 3))
                cycle(1'($urandom), 1'b1, ($urandom_range(0, 5) != 0), 2'($urandom));
        end

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
